wb_port_arbiter: RTL and testbench

Shares the register file's single write port between the in-order pipeline writeback (WB stage result: selected write data, rd, RegWrite) and a long-latency multiply/divide unit (MDU) that returns results out of band. MDU results are held in a small FIFO and drained into idle write-port cycles. A starvation guard stalls WB when a buffered result has waited too long. The block sits between the WB stage and the register file write port in the ID stage.

---
 rtl/wb_port_arbiter.sv | 114 +++++++++++
 tb/tb_wb_port_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register file write-port arbiter between WB writeback and a buffered MDU result FIFO
// Pipeline writes win; MDU results drain into idle cycles, with a starvation guard that stalls WB.
module wb_port_arbiter #(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pipe_valid,
   input  logic        RegWrite_WB,
   input  logic [4:0]  rd_WB,
   input  logic [31:0] writeData_WB,
   output logic        stall_WB,
   input  logic        mdu_valid,
   input  logic [4:0]  mdu_rd,
   input  logic [31:0] mdu_data,
   output logic        mdu_ready,
   output logic        rf_we,
   output logic [4:0]  rf_rd,
   output logic [31:0] rf_wd
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [SW-1:0] LIMIT    = SW'(STARVE_LIMIT);

   logic [DEPTH-1:0] ent_valid;
   logic [4:0]       ent_rd   [DEPTH];
   logic [31:0]      ent_data [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [CW-1:0]    count;
   logic [SW-1:0]    starve_cnt;

   logic pipe_req;
   logic head_present;
   logic head_live;
   logic head_killed;
   logic starve;
   logic grant_pipe;
   logic drain;
   logic pop;
   logic accept;
   logic push;

   assign pipe_req     = pipe_valid & RegWrite_WB & (rd_WB != 5'd0);
   assign head_present = (count != '0);
   assign head_live    = head_present & ent_valid[rd_ptr];
   assign head_killed  = head_present & ~ent_valid[rd_ptr];
   assign starve       = head_live & (starve_cnt == LIMIT);
   assign grant_pipe   = pipe_req & ~starve;
   assign drain        = head_live & (starve | ~pipe_req);
   assign pop          = drain | head_killed;

   // A full FIFO refuses even when the head pops this cycle.
   assign mdu_ready    = reset & (count < FULL_CNT);
   assign accept       = mdu_valid & mdu_ready;
   assign push         = accept & (mdu_rd != 5'd0);
   assign stall_WB     = reset & starve;

   always_ff @(posedge clk) begin
      if (!reset) begin
         rf_we      <= 1'b0;
         rf_rd      <= 5'd0;
         rf_wd      <= 32'd0;
         ent_valid  <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         starve_cnt <= '0;
      end else begin
         rf_we <= grant_pipe | drain;
         if (grant_pipe) begin
            rf_rd <= rd_WB;
            rf_wd <= writeData_WB;
         end else if (drain) begin
            rf_rd <= ent_rd[rd_ptr];
            rf_wd <= ent_data[rd_ptr];
         end

         // WAW: a newer pipeline write makes older buffered results to the same rd obsolete.
         for (int i = 0; i < DEPTH; i++) begin
            if (grant_pipe && (ent_rd[i] == rd_WB))
               ent_valid[i] <= 1'b0;
         end

         if (pop) begin
            ent_valid[rd_ptr] <= 1'b0;
            rd_ptr            <= rd_ptr + 1'b1;
         end

         if (push) begin
            ent_valid[wr_ptr] <= 1'b1;
            ent_rd[wr_ptr]    <= mdu_rd;
            ent_data[wr_ptr]  <= mdu_data;
            wr_ptr            <= wr_ptr + 1'b1;
         end

         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         if (!head_live || drain)
            starve_cnt <= '0;
         else if (starve_cnt != LIMIT)
            starve_cnt <= starve_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - directed self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;

   logic        clk;
   logic        reset;
   logic        pipe_valid;
   logic        RegWrite_WB;
   logic [4:0]  rd_WB;
   logic [31:0] writeData_WB;
   logic        stall_WB;
   logic        mdu_valid;
   logic [4:0]  mdu_rd;
   logic [31:0] mdu_data;
   logic        mdu_ready;
   logic        rf_we;
   logic [4:0]  rf_rd;
   logic [31:0] rf_wd;

   int n_checks = 0;
   int n_errors = 0;
   int stalls;
   logic [4:0]  q_rd [$];
   logic [31:0] q_wd [$];

   wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
      .clk(clk), .reset(reset),
      .pipe_valid(pipe_valid), .RegWrite_WB(RegWrite_WB), .rd_WB(rd_WB),
      .writeData_WB(writeData_WB), .stall_WB(stall_WB),
      .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
      .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Records MDU-originated writes (pipeline writes in these tests use rd 3).
   task automatic tick_rec();
      tick();
      if (rf_we && rf_rd != 5'd3) begin
         q_rd.push_back(rf_rd);
         q_wd.push_back(rf_wd);
      end
   endtask

   task automatic set_pipe(input logic v, input logic [4:0] rd, input logic [31:0] d);
      pipe_valid = v; RegWrite_WB = v; rd_WB = rd; writeData_WB = d;
   endtask

   task automatic set_mdu(input logic v, input logic [4:0] rd, input logic [31:0] d);
      mdu_valid = v; mdu_rd = rd; mdu_data = d;
   endtask

   initial begin
      // Reset held with every input active
      reset = 1'b0;
      set_pipe(1'b1, 5'd4, 32'h44);
      set_mdu(1'b1, 5'd6, 32'h66);
      for (int i = 0; i < 2; i++) begin
         tick();
         check("rst_rf_we", {31'd0, rf_we}, 32'd0);
         check("rst_ready", {31'd0, mdu_ready}, 32'd0);
         check("rst_stall", {31'd0, stall_WB}, 32'd0);
      end
      check("rst_rf_rd", {27'd0, rf_rd}, 32'd0);
      check("rst_rf_wd", rf_wd, 32'd0);
      set_pipe(1'b0, 5'd0, 32'd0);
      set_mdu(1'b0, 5'd0, 32'd0);
      reset = 1'b1;
      #1;
      check("rel_ready", {31'd0, mdu_ready}, 32'd1);

      // Idle drain: accept at t, write visible at t+2
      set_mdu(1'b1, 5'd5, 32'hDEADBEEF);
      #1;
      check("idle_ready", {31'd0, mdu_ready}, 32'd1);
      tick();
      set_mdu(1'b0, 5'd0, 32'd0);
      check("idle_t1_we", {31'd0, rf_we}, 32'd0);
      tick();
      check("idle_t2_we", {31'd0, rf_we}, 32'd1);
      check("idle_t2_rd", {27'd0, rf_rd}, 32'd5);
      check("idle_t2_wd", rf_wd, 32'hDEADBEEF);
      tick();
      check("idle_t3_we", {31'd0, rf_we}, 32'd0);

      // Starvation: rd 7 queued, then continuous pipeline writes to rd 3
      set_mdu(1'b1, 5'd7, 32'h77);
      tick();
      set_mdu(1'b0, 5'd0, 32'd0);
      set_pipe(1'b1, 5'd3, 32'h33);
      for (int k = 0; k < 4; k++) begin
         #1;
         check("stv_nostall", {31'd0, stall_WB}, 32'd0);
         tick();
         check("stv_pipe_we", {31'd0, rf_we}, 32'd1);
         check("stv_pipe_rd", {27'd0, rf_rd}, 32'd3);
         check("stv_pipe_wd", rf_wd, 32'h33);
      end
      #1;
      check("stv_stall", {31'd0, stall_WB}, 32'd1);
      tick();
      check("stv_mdu_we", {31'd0, rf_we}, 32'd1);
      check("stv_mdu_rd", {27'd0, rf_rd}, 32'd7);
      check("stv_mdu_wd", rf_wd, 32'h77);
      check("stv_after", {31'd0, stall_WB}, 32'd0);
      tick();
      check("stv_resume_rd", {27'd0, rf_rd}, 32'd3);
      check("stv_resume_we", {31'd0, rf_we}, 32'd1);
      set_pipe(1'b0, 5'd0, 32'd0);
      tick();
      tick();

      // Full FIFO with pipe_req held high
      q_rd.delete();
      q_wd.delete();
      set_pipe(1'b1, 5'd3, 32'h33);
      set_mdu(1'b1, 5'd10, 32'hA);
      #1;
      check("full_ready0", {31'd0, mdu_ready}, 32'd1);
      tick_rec();
      set_mdu(1'b1, 5'd11, 32'hB);
      #1;
      check("full_ready1", {31'd0, mdu_ready}, 32'd1);
      tick_rec();
      set_mdu(1'b1, 5'd12, 32'hC);
      for (int i = 0; i < 4; i++) begin
         #1;
         check("full_held", {31'd0, mdu_ready}, 32'd0);
         check("full_stall", {31'd0, stall_WB}, (i == 3) ? 32'd1 : 32'd0);
         tick_rec();
      end
      #1;
      check("full_freed", {31'd0, mdu_ready}, 32'd1);
      tick_rec();
      set_mdu(1'b0, 5'd0, 32'd0);
      stalls = 0;
      for (int i = 0; i < 16; i++) begin
         if (stall_WB) stalls++;
         tick_rec();
      end
      check("full_stalls", stalls, 32'd2);
      check("full_nwrites", q_rd.size(), 32'd3);
      if (q_rd.size() == 3) begin
         check("full_rd0", {27'd0, q_rd[0]}, 32'd10);
         check("full_wd0", q_wd[0], 32'hA);
         check("full_rd1", {27'd0, q_rd[1]}, 32'd11);
         check("full_wd1", q_wd[1], 32'hB);
         check("full_rd2", {27'd0, q_rd[2]}, 32'd12);
         check("full_wd2", q_wd[2], 32'hC);
      end
      set_pipe(1'b0, 5'd0, 32'd0);
      tick();
      tick();

      // WAW kill: rd 9 queued, pipeline write to rd 9 kills it; rd 13 behind it survives
      set_mdu(1'b1, 5'd9, 32'h99);
      tick();
      set_mdu(1'b1, 5'd13, 32'hD);
      set_pipe(1'b1, 5'd9, 32'h900);
      tick();
      set_mdu(1'b0, 5'd0, 32'd0);
      set_pipe(1'b0, 5'd0, 32'd0);
      check("waw_pipe_we", {31'd0, rf_we}, 32'd1);
      check("waw_pipe_wd", rf_wd, 32'h900);
      tick();
      check("waw_killed_we", {31'd0, rf_we}, 32'd0);
      tick();
      check("waw_next_we", {31'd0, rf_we}, 32'd1);
      check("waw_next_rd", {27'd0, rf_rd}, 32'd13);
      check("waw_next_wd", rf_wd, 32'hD);
      tick();
      check("waw_done_we", {31'd0, rf_we}, 32'd0);

      // x0 filtering on both sources
      set_pipe(1'b1, 5'd0, 32'h1234);
      set_mdu(1'b1, 5'd0, 32'h5678);
      for (int i = 0; i < 4; i++) begin
         #1;
         check("x0_ready", {31'd0, mdu_ready}, 32'd1);
         tick();
         check("x0_we", {31'd0, rf_we}, 32'd0);
      end
      set_pipe(1'b0, 5'd0, 32'd0);
      set_mdu(1'b0, 5'd0, 32'd0);
      tick();
      check("x0_tail_we", {31'd0, rf_we}, 32'd0);

      // Reset mid-operation discards buffered results
      set_pipe(1'b1, 5'd3, 32'h33);
      set_mdu(1'b1, 5'd20, 32'h20);
      tick();
      set_mdu(1'b1, 5'd21, 32'h21);
      tick();
      set_pipe(1'b0, 5'd0, 32'd0);
      set_mdu(1'b0, 5'd0, 32'd0);
      reset = 1'b0;
      tick();
      check("mid_rst_we", {31'd0, rf_we}, 32'd0);
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("mid_rst_flushed", {31'd0, rf_we}, 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
